csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
Machine-mode CSR storage block that sits directly downstream of exe. It consumes exe's registered CSR writeback, exception/trap information and mret/retire indications. It holds all M-mode CSRs plus 64-bit cycle/instret counters and provides a combinational read port to dec. It also drives mepc/mtvec/mstatus back to exe for trap redirection and return.

Parameters:
XLEN, 32, data width (only 32 supported)
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
HART_ID, 0, value returned by mhartid
MISA_VAL, 32'h4000_0100, read-only misa value (RV32I)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset
csr_rd_adr_i  in  12  dec read address
csr_rd_data_o  out  XLEN  read data for csr_rd_adr_i, combinational
csr_rd_illegal_o  out  1  address unimplemented, or a write is requested to a read-only CSR
csr_rd_wr_i  in  1  dec intends to write the addressed CSR (qualifies illegal)
csr_wbk_v_i  in  1  CSR write valid (exe csr_wbk_v_q)
csr_adr_i  in  12  CSR write address
csr_data_i  in  XLEN  CSR write data
exception_i  in  1  trap taken this cycle (exe exception_q)
mcause_i  in  XLEN  trap cause
mtval_i  in  XLEN  trap value
mepc_i  in  XLEN  faulting PC
core_mode_i  in  2  privilege at trap time
mret_i  in  1  mret retiring
instret_i  in  1  one instruction retired
mepc_q_o  out  XLEN  current mepc
mtvec_q_o  out  XLEN  current mtvec
mstatus_q_o  out  XLEN  current mstatus

Behaviour:
- Clocking and reset:
  - Interface: one clock (clk); reset is synchronous and active-high (reset).
  - On reset, all CSRs are 0 except: mtvec = MTVEC_RESET; mstatus.MPP = 2'b11.
  - Consequently, after reset: csr_rd_data_o reflects these values; mepc_q_o = 0; mtvec_q_o = MTVEC_RESET; mstatus_q_o = 32'h0000_1800.
- Latency: all register updates are visible one cycle after the input cycle. The read path is purely combinational from current state, with no write-to-read bypass (exe forwards in-flight CSR data itself).
- Address map:
  - Read/write: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
  - Read-only: misa 0x301, mip 0x344 (reads 0), cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82, mhartid 0xF14.
  - Any other address reads 0 and asserts csr_rd_illegal_o.
- Illegal flag: csr_rd_illegal_o = unimplemented | (csr_rd_wr_i & adr[11:10]==2'b11).
- Writes to read-only or unimplemented addresses are ignored.
- WARL fields:
  - mstatus: only MIE[3], MPIE[7], MPP[12:11] are writable; all other bits read 0. An MPP write of 01 or 10 keeps the old MPP.
  - mtvec: mode[1:0] accepts 0 or 1; a write with mode >= 2 keeps the old mode while the base still updates.
  - mepc: bits[1:0] are forced to 0 on every update.
  - mie: only bits 3, 7, 11 are writable.
- Counters:
  - mcycle (64-bit) increments every cycle not in reset.
  - minstret (64-bit) increments when instret_i = 1.
  - Both wrap 2^64-1 -> 0.
  - A CSR write to either half overrides that cycle's increment for the full 64-bit value: the written half takes the data, and the other half holds its value with no carry.
- Trap (exception_i = 1):
  - mepc <= mepc_i & ~3; mcause <= mcause_i; mtval <= mtval_i.
  - MPIE <= MIE; MIE <= 0; MPP <= core_mode_i.
- mret (mret_i = 1, no exception): MIE <= MPIE; MPIE <= 1; MPP <= 2'b00.
- Simultaneous events, priority exception > mret > CSR write:
  - The lower-priority update is dropped for every register the higher-priority event touches.
  - A CSR write to an untouched register (e.g. mscratch) still occurs alongside a trap.
  - instret_i is still counted when exception_i is set (exe qualifies the retire).
- Reset asserted mid-operation: reset wins over every write, trap and increment in that cycle.

Decomposition:
- riscv_pkg additions:
  - CSR address localparams (CSR_MSTATUS ... CSR_MHARTID).
  - mstatus bit-position constants (MSTATUS_MIE=3, MSTATUS_MPIE=7, MSTATUS_MPP=12:11).
  - Privilege mode constants (PRV_M=2'b11, PRV_U=2'b00).
- One sub-module csr_counter64: a 64-bit counter with inc_i, wr_lo_i, wr_hi_i, wr_data_i. Instantiated twice, for mcycle and minstret.

Test Plan:
- Reset then read 0x305, 0x300, 0xF14, 0x301 -> MTVEC_RESET, 0x0000_1800, HART_ID, 0x4000_0100; reading 0x7C0 -> data 0, illegal = 1.
- Write mstatus = 0xFFFF_FFFF -> reads 0x0000_1888. Then write 0x0000_0800 (MPP = 01) -> reads 0x0000_1800 (MPP kept at 11).
- MIE = 1, then exception_i with mepc_i = 0x1003, mcause_i = 2, mtval_i = 0xDEAD, core_mode_i = 11 -> next cycle mepc = 0x1000, mcause = 2, mtval = 0xDEAD, mstatus = 0x0000_1880. Then mret_i -> mstatus = 0x0000_0088.
- Same cycle: exception_i plus CSR write mepc = 0x4444 and mscratch = 0x55 (two separate runs) -> mepc takes the trap value; mscratch = 0x55.
- Write mcycle = 0xFFFF_FFFF with mcycleh = 0 -> one cycle later reads 0xFFFF_FFFF (increment suppressed). The next cycle mcycle = 0 and mcycleh = 1 (carry).
- Write minstreth = 7 with instret_i = 1 -> minstreth = 7 and minstret unchanged. Assert reset with instret_i = 1 -> all counters 0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants for the machine-mode CSR block: CSR
//                addresses, mstatus bit positions, privilege encodings and
//                address-decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Read/write machine CSRs
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // Read-only user shadows and hart identity
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Writable bits of mie (MSIE, MTIE, MEIE)
    localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

    // Privilege encodings
    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_M = 2'b11;

    // True when the address decodes to a CSR held by this block.
    function automatic logic csr_implemented(input logic [11:0] adr);
        logic hit;
        case (adr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
            CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
            CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH,
            CSR_MHARTID: hit = 1'b1;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

    // MPP only holds privilege levels this core implements (M and U).
    function automatic logic mpp_legal(input logic [1:0] mpp);
        return (mpp == PRV_M) || (mpp == PRV_U);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counter64
//  Description : 64-bit event counter with independently writable 32-bit
//                halves. A write to either half takes precedence over the
//                increment in the same cycle; the other half holds with no
//                carry applied.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                inc_i          - count one event this cycle
//                wr_lo_i        - load count[31:0] from wr_data_i
//                wr_hi_i        - load count[63:32] from wr_data_i
//                wr_data_i      - write data
//                count_o        - current 64-bit count
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wr_data_i,
    output logic [63:0] count_o
);

    logic [63:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 64'd0;
        end else if (wr_lo_i) begin
            r_count[31:0] <= wr_data_i;
        end else if (wr_hi_i) begin
            r_count[63:32] <= wr_data_i;
        end else if (inc_i) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
//  Module      : csr_file
//  Description : Machine-mode CSR storage. Accepts registered CSR writeback,
//                trap and mret events from exe, keeps the 64-bit cycle and
//                instret counters, and offers a combinational read port to
//                dec. Trap/return state (mepc, mtvec, mstatus) is exported
//                back to exe.
//  Ports       : clk, reset              - clock, synchronous active-high reset
//                csr_rd_adr_i/_wr_i      - dec read address / write intent
//                csr_rd_data_o           - combinational read data
//                csr_rd_illegal_o        - unimplemented or write to read-only
//                csr_wbk_v_i/adr_i/data_i- CSR write from exe
//                exception_i, mcause_i, mtval_i, mepc_i, core_mode_i - trap
//                mret_i, instret_i       - return / retire indications
//                mepc_q_o, mtvec_q_o, mstatus_q_o - state back to exe
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_file
    import riscv_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          HART_ID     = 0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [11:0]     csr_rd_adr_i,
    output logic [XLEN-1:0] csr_rd_data_o,
    output logic            csr_rd_illegal_o,
    input  logic            csr_rd_wr_i,
    input  logic            csr_wbk_v_i,
    input  logic [11:0]     csr_adr_i,
    input  logic [XLEN-1:0] csr_data_i,
    input  logic            exception_i,
    input  logic [XLEN-1:0] mcause_i,
    input  logic [XLEN-1:0] mtval_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [1:0]      core_mode_i,
    input  logic            mret_i,
    input  logic            instret_i,
    output logic [XLEN-1:0] mepc_q_o,
    output logic [XLEN-1:0] mtvec_q_o,
    output logic [XLEN-1:0] mstatus_q_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            r_mie_bit;
    logic            r_mpie_bit;
    logic [1:0]      r_mpp;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:2] r_mtvec_base;
    logic [1:0]      r_mtvec_mode;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;

    logic [63:0]     w_mcycle;
    logic [63:0]     w_minstret;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mtvec;

    // ------------------------------------------------------------------
    // Write decode (one-hot per writable register)
    // ------------------------------------------------------------------
    logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch;
    logic w_wr_mepc, w_wr_mcause, w_wr_mtval;
    logic w_wr_mcycle, w_wr_mcycleh, w_wr_minstret, w_wr_minstreth;

    assign w_wr_mstatus   = csr_wbk_v_i && (csr_adr_i == CSR_MSTATUS);
    assign w_wr_mie       = csr_wbk_v_i && (csr_adr_i == CSR_MIE);
    assign w_wr_mtvec     = csr_wbk_v_i && (csr_adr_i == CSR_MTVEC);
    assign w_wr_mscratch  = csr_wbk_v_i && (csr_adr_i == CSR_MSCRATCH);
    assign w_wr_mepc      = csr_wbk_v_i && (csr_adr_i == CSR_MEPC);
    assign w_wr_mcause    = csr_wbk_v_i && (csr_adr_i == CSR_MCAUSE);
    assign w_wr_mtval     = csr_wbk_v_i && (csr_adr_i == CSR_MTVAL);
    assign w_wr_mcycle    = csr_wbk_v_i && (csr_adr_i == CSR_MCYCLE);
    assign w_wr_mcycleh   = csr_wbk_v_i && (csr_adr_i == CSR_MCYCLEH);
    assign w_wr_minstret  = csr_wbk_v_i && (csr_adr_i == CSR_MINSTRET);
    assign w_wr_minstreth = csr_wbk_v_i && (csr_adr_i == CSR_MINSTRETH);

    // ------------------------------------------------------------------
    // Register updates. Priority: exception > mret > CSR write, applied
    // per register, so a write to a register the trap does not touch
    // (mscratch, mie, mtvec) still lands alongside the trap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mie_bit    <= 1'b0;
            r_mpie_bit   <= 1'b0;
            r_mpp        <= PRV_M;
            r_mie        <= '0;
            r_mtvec_base <= MTVEC_RESET[XLEN-1:2];
            r_mtvec_mode <= MTVEC_RESET[1:0];
            r_mscratch   <= '0;
            r_mepc       <= '0;
            r_mcause     <= '0;
            r_mtval      <= '0;
        end else begin
            // mstatus
            if (exception_i) begin
                r_mpie_bit <= r_mie_bit;
                r_mie_bit  <= 1'b0;
                r_mpp      <= core_mode_i;
            end else if (mret_i) begin
                r_mie_bit  <= r_mpie_bit;
                r_mpie_bit <= 1'b1;
                r_mpp      <= PRV_U;
            end else if (w_wr_mstatus) begin
                r_mie_bit  <= csr_data_i[MSTATUS_MIE];
                r_mpie_bit <= csr_data_i[MSTATUS_MPIE];
                if (mpp_legal(csr_data_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO])) begin
                    r_mpp <= csr_data_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                end
            end

            // Trap-owned registers
            if (exception_i) begin
                r_mepc   <= {mepc_i[XLEN-1:2], 2'b00};
                r_mcause <= mcause_i;
                r_mtval  <= mtval_i;
            end else begin
                if (w_wr_mepc) begin
                    r_mepc <= {csr_data_i[XLEN-1:2], 2'b00};
                end
                if (w_wr_mcause) begin
                    r_mcause <= csr_data_i;
                end
                if (w_wr_mtval) begin
                    r_mtval <= csr_data_i;
                end
            end

            // Registers no event other than a CSR write touches
            if (w_wr_mie) begin
                r_mie <= csr_data_i & MIE_WMASK;
            end
            if (w_wr_mtvec) begin
                r_mtvec_base <= csr_data_i[XLEN-1:2];
                // Only direct (0) and vectored (1) modes exist
                if (!csr_data_i[1]) begin
                    r_mtvec_mode <= csr_data_i[1:0];
                end
            end
            if (w_wr_mscratch) begin
                r_mscratch <= csr_data_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    csr_counter64 u_mcycle (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (1'b1),
        .wr_lo_i   (w_wr_mcycle),
        .wr_hi_i   (w_wr_mcycleh),
        .wr_data_i (csr_data_i),
        .count_o   (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (instret_i),
        .wr_lo_i   (w_wr_minstret),
        .wr_hi_i   (w_wr_minstreth),
        .wr_data_i (csr_data_i),
        .count_o   (w_minstret)
    );

    // ------------------------------------------------------------------
    // Read port (pure function of current state, no write bypass)
    // ------------------------------------------------------------------
    always_comb begin
        w_mstatus                                = '0;
        w_mstatus[MSTATUS_MIE]                   = r_mie_bit;
        w_mstatus[MSTATUS_MPIE]                  = r_mpie_bit;
        w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = r_mpp;
    end

    assign w_mtvec = {r_mtvec_base, r_mtvec_mode};

    always_comb begin
        csr_rd_data_o = '0;
        case (csr_rd_adr_i)
            CSR_MSTATUS:   csr_rd_data_o = w_mstatus;
            CSR_MISA:      csr_rd_data_o = MISA_VAL;
            CSR_MIE:       csr_rd_data_o = r_mie;
            CSR_MTVEC:     csr_rd_data_o = w_mtvec;
            CSR_MSCRATCH:  csr_rd_data_o = r_mscratch;
            CSR_MEPC:      csr_rd_data_o = r_mepc;
            CSR_MCAUSE:    csr_rd_data_o = r_mcause;
            CSR_MTVAL:     csr_rd_data_o = r_mtval;
            CSR_MCYCLE,
            CSR_CYCLE:     csr_rd_data_o = w_mcycle[31:0];
            CSR_MCYCLEH,
            CSR_CYCLEH:    csr_rd_data_o = w_mcycle[63:32];
            CSR_MINSTRET,
            CSR_INSTRET:   csr_rd_data_o = w_minstret[31:0];
            CSR_MINSTRETH,
            CSR_INSTRETH:  csr_rd_data_o = w_minstret[63:32];
            CSR_MHARTID:   csr_rd_data_o = XLEN'(HART_ID);
            default:       csr_rd_data_o = '0;   // mip and unimplemented
        endcase
    end

    // Address bits [11:10] == 2'b11 mark the architecturally read-only space.
    assign csr_rd_illegal_o = !csr_implemented(csr_rd_adr_i) ||
                              (csr_rd_wr_i && (csr_rd_adr_i[11:10] == 2'b11));

    assign mepc_q_o    = r_mepc;
    assign mtvec_q_o   = w_mtvec;
    assign mstatus_q_o = w_mstatus;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_file
//  Description : Directed self-checking bench for csr_file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    localparam logic [31:0] C_MTVEC_RESET = 32'h8000_0000;
    localparam int          C_HART_ID     = 3;

    logic        clk;
    logic        reset;
    logic [11:0] csr_rd_adr_i;
    logic [31:0] csr_rd_data_o;
    logic        csr_rd_illegal_o;
    logic        csr_rd_wr_i;
    logic        csr_wbk_v_i;
    logic [11:0] csr_adr_i;
    logic [31:0] csr_data_i;
    logic        exception_i;
    logic [31:0] mcause_i;
    logic [31:0] mtval_i;
    logic [31:0] mepc_i;
    logic [1:0]  core_mode_i;
    logic        mret_i;
    logic        instret_i;
    logic [31:0] mepc_q_o;
    logic [31:0] mtvec_q_o;
    logic [31:0] mstatus_q_o;

    int n_checks;
    int n_fails;

    csr_file #(
        .XLEN        (32),
        .MTVEC_RESET (C_MTVEC_RESET),
        .HART_ID     (C_HART_ID),
        .MISA_VAL    (32'h4000_0100)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .csr_rd_adr_i     (csr_rd_adr_i),
        .csr_rd_data_o    (csr_rd_data_o),
        .csr_rd_illegal_o (csr_rd_illegal_o),
        .csr_rd_wr_i      (csr_rd_wr_i),
        .csr_wbk_v_i      (csr_wbk_v_i),
        .csr_adr_i        (csr_adr_i),
        .csr_data_i       (csr_data_i),
        .exception_i      (exception_i),
        .mcause_i         (mcause_i),
        .mtval_i          (mtval_i),
        .mepc_i           (mepc_i),
        .core_mode_i      (core_mode_i),
        .mret_i           (mret_i),
        .instret_i        (instret_i),
        .mepc_q_o         (mepc_q_o),
        .mtvec_q_o        (mtvec_q_o),
        .mstatus_q_o      (mstatus_q_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] adr, input logic [31:0] exp);
        csr_rd_adr_i = adr;
        #1;
        check(tag, csr_rd_data_o, exp);
    endtask

    task automatic ill(input string tag, input logic [11:0] adr, input logic wr, input logic exp);
        csr_rd_adr_i = adr;
        csr_rd_wr_i  = wr;
        #1;
        check(tag, {31'd0, csr_rd_illegal_o}, {31'd0, exp});
        csr_rd_wr_i  = 1'b0;
    endtask

    task automatic set_wr(input logic [11:0] adr, input logic [31:0] data);
        csr_wbk_v_i = 1'b1;
        csr_adr_i   = adr;
        csr_data_i  = data;
    endtask

    task automatic clr_in();
        csr_wbk_v_i = 1'b0;
        exception_i = 1'b0;
        mret_i      = 1'b0;
        instret_i   = 1'b0;
    endtask

    task automatic wr(input logic [11:0] adr, input logic [31:0] data);
        set_wr(adr, data);
        tick();
        clr_in();
    endtask

    task automatic trap(input logic [31:0] pc, input logic [31:0] cause,
                        input logic [31:0] tval, input logic [1:0] mode);
        exception_i = 1'b1;
        mepc_i      = pc;
        mcause_i    = cause;
        mtval_i     = tval;
        core_mode_i = mode;
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        reset        = 1'b1;
        csr_rd_adr_i = 12'h000;
        csr_rd_wr_i  = 1'b0;
        csr_adr_i    = 12'h000;
        csr_data_i   = 32'h0;
        mcause_i     = 32'h0;
        mtval_i      = 32'h0;
        mepc_i       = 32'h0;
        core_mode_i  = 2'b00;
        clr_in();
        tick();
        tick();

        // Reset state (reset still high, so counters are held at 0)
        check("rst_mepc_q",    mepc_q_o,    32'h0);
        check("rst_mtvec_q",   mtvec_q_o,   C_MTVEC_RESET);
        check("rst_mstatus_q", mstatus_q_o, 32'h0000_1800);
        rd("rst_mtvec",   12'h305, C_MTVEC_RESET);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mhartid", 12'hF14, 32'd3);
        rd("rst_misa",    12'h301, 32'h4000_0100);
        rd("rst_mip",     12'h344, 32'h0);
        rd("rst_mcycle",  12'hB00, 32'h0);
        rd("unimpl_data", 12'h7C0, 32'h0);
        ill("unimpl_ill",  12'h7C0, 1'b0, 1'b1);
        ill("mstatus_ill", 12'h300, 1'b1, 1'b0);
        ill("cycle_rd_ok", 12'hC00, 1'b0, 1'b0);
        ill("cycle_wr_ill",12'hC00, 1'b1, 1'b1);
        ill("hartid_wr",   12'hF14, 1'b1, 1'b1);
        reset = 1'b0;

        // mstatus WARL
        wr(12'h300, 32'hFFFF_FFFF);
        rd("mstatus_all1", 12'h300, 32'h0000_1888);
        wr(12'h300, 32'h0000_0800);
        rd("mstatus_mpp01", 12'h300, 32'h0000_1800);
        wr(12'h300, 32'h0000_0008);
        rd("mstatus_mppU", 12'h300, 32'h0000_0008);

        // mie / mtvec / mepc WARL, write to read-only ignored
        wr(12'h304, 32'hFFFF_FFFF);
        rd("mie_mask", 12'h304, 32'h0000_0888);
        wr(12'h305, 32'h0000_1236);
        rd("mtvec_mode2", 12'h305, 32'h0000_1234);
        wr(12'h305, 32'h0000_5001);
        rd("mtvec_mode1", 12'h305, 32'h0000_5001);
        wr(12'h305, 32'h0000_7003);
        rd("mtvec_mode3", 12'h305, 32'h0000_7001);
        check("mtvec_q", mtvec_q_o, 32'h0000_7001);
        wr(12'h341, 32'h0000_1237);
        rd("mepc_align", 12'h341, 32'h0000_1234);
        wr(12'hF14, 32'h0000_00AA);
        rd("hartid_ro", 12'hF14, 32'd3);

        // Trap then mret
        wr(12'h300, 32'h0000_1808);
        trap(32'h0000_1003, 32'd2, 32'h0000_DEAD, 2'b11);
        tick();
        clr_in();
        check("trap_mepc_q",    mepc_q_o,    32'h0000_1000);
        check("trap_mstatus_q", mstatus_q_o, 32'h0000_1880);
        rd("trap_mcause", 12'h342, 32'd2);
        rd("trap_mtval",  12'h343, 32'h0000_DEAD);
        mret_i = 1'b1;
        tick();
        clr_in();
        check("mret_mstatus", mstatus_q_o, 32'h0000_0088);

        // mret wins over a same-cycle mstatus write
        mret_i = 1'b1;
        set_wr(12'h300, 32'h0000_1800);
        tick();
        clr_in();
        check("mret_vs_wr", mstatus_q_o, 32'h0000_0088);

        // Exception wins over a same-cycle mepc write
        trap(32'h0000_2002, 32'd5, 32'h0, 2'b00);
        set_wr(12'h341, 32'h0000_4444);
        tick();
        clr_in();
        check("trap_vs_mepc", mepc_q_o, 32'h0000_2000);
        check("trap_mpp_u",   mstatus_q_o, 32'h0000_0080);

        // Untouched register still written alongside a trap
        trap(32'h0000_3000, 32'd7, 32'h0, 2'b11);
        set_wr(12'h340, 32'h0000_0055);
        tick();
        clr_in();
        rd("trap_mscratch", 12'h340, 32'h0000_0055);
        rd("trap2_mcause",  12'h342, 32'd7);

        // mcycle: write suppresses increment, then carry into high half
        wr(12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_wr",   12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_wr",  12'hB80, 32'h0);
        tick();
        rd("mcycle_wrap", 12'hB00, 32'h0);
        rd("mcycleh_cy",  12'hB80, 32'h1);
        rd("cycleh_ro",   12'hC80, 32'h1);

        // minstret: no retire so far; high write suppresses increment
        rd("minstret_0", 12'hB02, 32'h0);
        instret_i = 1'b1;
        set_wr(12'hB82, 32'd7);
        tick();
        clr_in();
        rd("minstreth_wr", 12'hB82, 32'd7);
        rd("minstret_hld", 12'hB02, 32'd0);
        instret_i = 1'b1;
        tick();
        clr_in();
        rd("minstret_inc", 12'hB02, 32'd1);
        instret_i = 1'b1;
        trap(32'h0000_4000, 32'd3, 32'h0, 2'b11);
        tick();
        clr_in();
        rd("instret_exc", 12'hC02, 32'd2);
        rd("instreth_ro", 12'hC82, 32'd7);

        // Reset overrides increment and writes in the same cycle
        reset     = 1'b1;
        instret_i = 1'b1;
        set_wr(12'h340, 32'h0000_0099);
        tick();
        clr_in();
        rd("rst2_minstret",  12'hB02, 32'h0);
        rd("rst2_minstreth", 12'hB82, 32'h0);
        rd("rst2_mcycle",    12'hB00, 32'h0);
        rd("rst2_mcycleh",   12'hB80, 32'h0);
        rd("rst2_mscratch",  12'h340, 32'h0);
        check("rst2_mstatus", mstatus_q_o, 32'h0000_1800);
        check("rst2_mtvec",   mtvec_q_o,   C_MTVEC_RESET);
        reset = 1'b0;
        tick();
        rd("post_rst_cyc", 12'hB00, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
